// File: rtl/seq_divmod.sv
// Sequential unsigned divider. It computes one restoring shift-subtract step per clock and produces quotient and remainder.
// Defining SEQ_DIVMOD_DBZ_FAST_EN makes a zero divisor go from acceptance straight to DONE.
module seq_divmod #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(DATAWIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic [CW-1:0]        cnt_r;
    logic [DATAWIDTH-1:0] dvd_r;
    logic [DATAWIDTH-1:0] dvs_r;
    logic [DATAWIDTH-1:0] part_r;

    logic                 last_s;
    logic                 fast_dbz_s;
    logic [DATAWIDTH:0]   shift_s;
    logic                 ge_s;
    logic [DATAWIDTH-1:0] diff_s;
    logic [DATAWIDTH-1:0] part_nx_s;
    logic [DATAWIDTH-1:0] quot_nx_s;

`ifdef SEQ_DIVMOD_DBZ_FAST_EN
    assign fast_dbz_s = (b == {DATAWIDTH{1'b0}});
`else
    assign fast_dbz_s = 1'b0;
`endif

    assign last_s = (cnt_r == LAST_ITER);
    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);

    // One restoring iteration. The partial remainder is extended by one bit so it can hold the next dividend bit.
    always_comb begin
        shift_s   = {part_r, dvd_r[DATAWIDTH-1]};
        ge_s      = (shift_s >= {1'b0, dvs_r});
        diff_s    = shift_s[DATAWIDTH-1:0] - dvs_r;
        quot_nx_s = {dvd_r[DATAWIDTH-2:0], ge_s};
        if (ge_s) begin
            part_nx_s = diff_s;
        end else begin
            part_nx_s = shift_s[DATAWIDTH-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nx_s = fast_dbz_s ? DONE : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and result registers. The results load only on entry to DONE, so they hold between divisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= {CW{1'b0}};
            dvd_r       <= {DATAWIDTH{1'b0}};
            dvs_r       <= {DATAWIDTH{1'b0}};
            part_r      <= {DATAWIDTH{1'b0}};
            quot        <= {DATAWIDTH{1'b0}};
            rem         <= {DATAWIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_r  <= {CW{1'b0}};
                        dvd_r  <= a;
                        dvs_r  <= b;
                        part_r <= {DATAWIDTH{1'b0}};
                        if (fast_dbz_s) begin
                            quot        <= {DATAWIDTH{1'b1}};
                            rem         <= a;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_r  <= cnt_r + CW'(1);
                    dvd_r  <= quot_nx_s;
                    part_r <= part_nx_s;
                    // A zero divisor naturally yields all-ones quotient and remainder equal to the dividend.
                    if (last_s) begin
                        quot        <= quot_nx_s;
                        rem         <= part_nx_s;
                        div_by_zero <= (dvs_r == {DATAWIDTH{1'b0}});
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod. A cycle-count/arithmetic reference model is checked on every falling edge.
// Hand-computed literals pin the latency and the results of each vector.
module tb_seq_divmod;
    localparam int DW = 8;
`ifdef SEQ_DIVMOD_DBZ_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quot, rem;

    int n_cmp = 0;
    int n_err = 0;

    seq_divmod #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*DW:0] ref_div(input logic [DW-1:0] x, input logic [DW-1:0] y);
        if (y == '0) return {1'b1, {DW{1'b1}}, x};
        return {1'b0, DW'(x / y), DW'(x % y)};
    endfunction

    // Reference model: remaining busy cycles plus the pending and visible results.
    int            m_left;
    logic          m_done, m_d, p_d;
    logic [DW-1:0] m_q, m_r, p_q, p_r;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0; m_done <= 1'b0;
            m_q <= '0; m_r <= '0; m_d <= 1'b0;
            p_q <= '0; p_r <= '0; p_d <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_q <= p_q; m_r <= p_r; m_d <= p_d;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (FAST && b == '0) begin
                    m_done <= 1'b1;
                    {m_d, m_q, m_r} <= ref_div(a, b);
                end else begin
                    m_left <= DW;
                    {p_d, p_q, p_r} <= ref_div(a, b);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("mon_busy", busy, m_left > 0);
        check("mon_done", done, m_done);
        check("mon_quot", quot, m_q);
        check("mon_rem", rem, m_r);
        check("mon_dbz", div_by_zero, m_d);
    end

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_div(input bit sync, input logic [DW-1:0] ta, input logic [DW-1:0] tb_v,
                           input logic [DW-1:0] eq, input logic [DW-1:0] er, input logic ed,
                           input int elat, input string tag);
        int cyc;
        if (sync) begin
            @(posedge clk); #1;
        end
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        wait_done(cyc);
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_dbz"}, div_by_zero, ed);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_quot", quot, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;

        // Abort a division mid-run with reset.
        @(posedge clk); #1;
        a = 8'd50; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rem", rem, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_div(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, "d100_7");

        run_div(1'b1, 8'd7, 8'd100, 8'd0, 8'd7, 1'b0, 8, "d7_100");
        run_div(1'b1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, "d255_1");
        run_div(1'b1, 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8, "d0_5");
        run_div(1'b1, 8'd37, 8'd0, 8'd255, 8'd37, 1'b1, FAST ? 0 : 8, "d37_0");
        run_div(1'b1, 8'd13, 8'd13, 8'd1, 8'd0, 1'b0, 8, "d13_13");

        // Start while busy is ignored.
        @(posedge clk); #1;
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'd9; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 3;
        wait_done(cyc);
        check("ign_lat", cyc, 8);
        check("ign_quot", quot, 14);
        check("ign_rem", rem, 2);

        // Start held across DONE: back-to-back divisions.
        @(posedge clk); #1;
        a = 8'd200; b = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        wait_done(cyc);
        check("b2b1_lat", cyc, 8);
        check("b2b1_quot", quot, 22);
        check("b2b1_rem", rem, 2);
        a = 8'd50; b = 8'd6;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_low", done, 0);
        check("b2b_busy", busy, 1);
        cyc = 0;
        wait_done(cyc);
        check("b2b2_lat", cyc, 8);
        check("b2b2_quot", quot, 8);
        check("b2b2_rem", rem, 2);

        // Reset after results: outputs clear and hold.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst2_quot", quot, 0);
        check("rst2_rem", rem, 0);
        check("rst2_dbz", div_by_zero, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end
endmodule
